// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: collects external and timer interrupt pulses into a pending
// register, and arbitrates among the enabled ones with a fixed priority.
// It presents the winner to the privilege unit as a level request (eip) and
// waits for the acknowledge. After each acknowledge it enforces a short quiet
// gap before the next request is raised.
// The register block gives PENDING (W1C), MASK, and CLAIM (last acknowledged
// grant).
module interrupt_ctrl #(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq,
  input  logic            timer_irq,
  input  logic [3:0]      a,
  input  logic [31:0]     d,
  input  logic            we,
  output logic [31:0]     spo,
  output logic            eip,
  output logic            eip_istimer,
  input  logic            eip_reply
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  logic [NSRC:0] pend_r;
  logic [NSRC:0] mask_r;
  logic [1:0]    state_r;
  logic [1:0]    gap_r;
  logic [2:0]    grant_id_r;
  logic          grant_tmr_r;
  logic          claim_valid_r;
  logic          claim_tmr_r;
  logic [2:0]    claim_id_r;
  logic          eip_r;
  logic          eip_tmr_r;

  logic [NSRC:0] elig_s;
  logic [NSRC:0] set_s;
  logic [NSRC:0] clr_s;
  logic [2:0]    sel_id_s;
  logic          sel_tmr_s;
  logic          sel_any_s;
  logic          ack_s;
  logic          unused_s;

  assign elig_s      = pend_r & mask_r;
  assign set_s       = {timer_irq, irq};
  assign ack_s       = (state_r == ST_ASSERT) && eip_reply;
  assign eip         = eip_r;
  assign eip_istimer = eip_tmr_r;
  // Low address bits and upper data bits carry no meaning for this block.
  assign unused_s    = ^{a[1:0], d};

  // Fixed-priority arbiter: lowest-index eligible external source wins, the
  // timer only when no external source is eligible.
  always_comb begin
    sel_id_s  = 3'd0;
    sel_any_s = |elig_s;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig_s[i]) begin
        sel_id_s = 3'(i);
      end else begin
        sel_id_s = sel_id_s;
      end
    end
    sel_tmr_s = elig_s[NSRC] & ~(|elig_s[NSRC-1:0]);
  end

  // Bits to clear this cycle: software W1C plus the acknowledged grant.
  always_comb begin
    clr_s = '0;
    if (we && (a[3:2] == 2'd0)) begin
      clr_s = d[NSRC:0];
    end else begin
      clr_s = '0;
    end
    if (ack_s) begin
      if (grant_tmr_r) begin
        clr_s[NSRC] = 1'b1;
      end else begin
        for (int i = 0; i < NSRC; i++) begin
          if (int'(grant_id_r) == i) begin
            clr_s[i] = 1'b1;
          end else begin
            clr_s[i] = clr_s[i];
          end
        end
      end
    end else begin
      clr_s = clr_s;
    end
  end

  // Combinational register read mux.
  always_comb begin
    case (a[3:2])
      2'd0:    spo = {{(31 - NSRC){1'b0}}, pend_r};
      2'd1:    spo = {{(31 - NSRC){1'b0}}, mask_r};
      2'd2:    spo = {claim_valid_r, 22'd0, claim_tmr_r, 5'd0, claim_id_r};
      default: spo = 32'd0;
    endcase
  end

  // Pending bits: a new pulse always wins over any clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r <= '0;
    end else begin
      pend_r <= (pend_r & ~clr_s) | set_s;
    end
  end

  // Mask register, writable at any time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r <= '0;
    end else if (we && (a[3:2] == 2'd1)) begin
      mask_r <= d[NSRC:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Request handshake FSM: arbitrate, hold the request, then enforce the gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      gap_r         <= 2'd0;
      grant_id_r    <= 3'd0;
      grant_tmr_r   <= 1'b0;
      claim_valid_r <= 1'b0;
      claim_tmr_r   <= 1'b0;
      claim_id_r    <= 3'd0;
      eip_r         <= 1'b0;
      eip_tmr_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_any_s) begin
            grant_tmr_r <= sel_tmr_s;
            grant_id_r  <= sel_tmr_s ? 3'd0 : sel_id_s;
            eip_r       <= 1'b1;
            eip_tmr_r   <= sel_tmr_s;
            state_r     <= ST_ASSERT;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ASSERT: begin
          if (eip_reply) begin
            eip_r         <= 1'b0;
            eip_tmr_r     <= 1'b0;
            claim_valid_r <= 1'b1;
            claim_tmr_r   <= grant_tmr_r;
            claim_id_r    <= grant_id_r;
            gap_r         <= 2'd2;
            state_r       <= ST_GAP;
          end else begin
            state_r       <= ST_ASSERT;
          end
        end
        ST_GAP: begin
          if (gap_r <= 2'd1) begin
            gap_r   <= 2'd0;
            state_r <= ST_IDLE;
          end else begin
            gap_r   <= gap_r - 2'd1;
            state_r <= ST_GAP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          gap_r     <= 2'd0;
          eip_r     <= 1'b0;
          eip_tmr_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Testbench for interrupt_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the controller.
module tb_interrupt_ctrl;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          timer_irq;
  logic [3:0]    a;
  logic [31:0]   d;
  logic          we;
  logic [31:0]   spo;
  logic          eip;
  logic          eip_istimer;
  logic          eip_reply;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [N:0] m_pend;
  logic [N:0] m_mask;
  bit         m_eip;
  bit         m_tmr;
  int         m_gid;
  bit         m_gtmr;
  bit         m_cv;
  bit         m_ct;
  logic [2:0] m_cid;
  int         m_quiet;

  interrupt_ctrl #(.NSRC(N)) dut (
    .clk(clk), .rst(rst), .irq(irq), .timer_irq(timer_irq), .a(a), .d(d),
    .we(we), .spo(spo), .eip(eip), .eip_istimer(eip_istimer),
    .eip_reply(eip_reply)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_eip = 0; m_tmr = 0; m_gid = 0; m_gtmr = 0;
    m_cv = 0; m_ct = 0; m_cid = 3'd0; m_quiet = 0;
  endtask

  function automatic logic [31:0] exp_spo(input logic [3:0] ad);
    case (ad[3:2])
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return {m_cv, 22'd0, m_ct, 5'd0, m_cid};
      default: return 32'd0;
    endcase
  endfunction

  // One clock: advance the model with the applied inputs, then compare.
  task automatic tick();
    logic [N:0] setv, clrv, elig;
    bit found;
    setv = {timer_irq, irq};
    clrv = '0;
    if (we && a[3:2] == 2'd0) clrv = d[N:0];
    elig = m_pend & m_mask;
    if (m_eip) begin
      if (eip_reply) begin
        if (m_gtmr) clrv[N] = 1'b1; else clrv[m_gid] = 1'b1;
        m_cv = 1; m_ct = m_gtmr; m_cid = m_gtmr ? 3'd0 : 3'(m_gid);
        m_eip = 0; m_tmr = 0;
        m_quiet = 2;  // two more low edges before arbitration resumes
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (elig != '0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && elig[i]) begin
          found = 1; m_gid = i;
        end
      end
      m_gtmr = !found;
      if (!found) m_gid = 0;
      m_eip = 1; m_tmr = m_gtmr;
    end
    m_pend = (m_pend & ~clrv) | setv;
    if (we && a[3:2] == 2'd1) m_mask = d[N:0];
    @(posedge clk);
    @(negedge clk);
    check_eq("eip", 32'(eip), 32'(m_eip));
    check_eq("eip_istimer", 32'(eip_istimer), 32'(m_tmr));
    check_eq("spo", spo, exp_spo(a));
  endtask

  task automatic cyc(input logic [N-1:0] iv, input logic t, input logic r,
                     input logic w, input logic [3:0] ad, input logic [31:0] dd);
    irq = iv; timer_irq = t; eip_reply = r; we = w; a = ad; d = dd;
    tick();
    irq = '0; timer_irq = 1'b0; eip_reply = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0, 1'b0, a, 32'd0);
  endtask

  task automatic peek(input logic [3:0] ad, input logic [31:0] exp, input string tag);
    a = ad;
    #1;
    check_eq(tag, spo, exp);
  endtask

  initial begin
    rst = 1'b0; irq = '0; timer_irq = 1'b0; a = 4'd0; d = 32'd0; we = 1'b0;
    eip_reply = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_eip", 32'(eip), 32'd0);
    check_eq("rst_istimer", 32'(eip_istimer), 32'd0);
    peek(4'h0, 32'd0, "rst_pend");
    peek(4'h4, 32'd0, "rst_mask");
    peek(4'h8, 32'd0, "rst_claim");
    rst = 1'b1;

    // Single external source, full handshake.
    cyc('0, 0, 0, 1, 4'h4, 32'h1F);
    cyc(4'b0100, 0, 0, 0, 4'h0, 32'd0);
    cyc('0, 0, 0, 0, 4'h0, 32'd0);
    check_eq("s1_eip", 32'(eip), 32'd1);
    check_eq("s1_ext", 32'(eip_istimer), 32'd0);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);
    check_eq("s1_drop", 32'(eip), 32'd0);
    peek(4'h8, 32'h8000_0002, "s1_claim");
    peek(4'h0, 32'd0, "s1_pend");
    idle(3);

    // Timer and external together: external first, timer after the gap.
    cyc(4'b1000, 1, 0, 0, 4'h0, 32'd0);
    cyc('0, 0, 0, 0, 4'h0, 32'd0);
    check_eq("s2_eip", 32'(eip), 32'd1);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);
    peek(4'h8, 32'h8000_0003, "s2_claim_ext");
    idle(2);
    check_eq("s2_gap_low", 32'(eip), 32'd0);
    idle(1);
    check_eq("s2_tmr_eip", 32'(eip), 32'd1);
    check_eq("s2_tmr_ist", 32'(eip_istimer), 32'd1);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);
    peek(4'h8, 32'h8000_0100, "s2_claim_tmr");
    idle(3);

    // Masked source stays pending until enabled.
    cyc('0, 0, 0, 1, 4'h4, 32'h0);
    cyc(4'b0001, 0, 0, 0, 4'h0, 32'd0);
    peek(4'h0, 32'h1, "s3_pend");
    idle(1);
    check_eq("s3_masked", 32'(eip), 32'd0);
    cyc('0, 0, 0, 1, 4'h4, 32'h1);
    idle(1);
    check_eq("s3_unmask", 32'(eip), 32'd1);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);
    idle(3);
    cyc('0, 0, 0, 1, 4'h4, 32'h1F);

    // New pulse in the reply cycle survives the grant clear.
    cyc(4'b0010, 0, 0, 0, 4'h0, 32'd0);
    idle(1);
    cyc(4'b0010, 0, 1, 0, 4'h0, 32'd0);
    peek(4'h0, 32'h2, "s4_pend");
    idle(3);
    check_eq("s4_second", 32'(eip), 32'd1);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);
    idle(3);

    // W1C of everything during ASSERT does not disturb the handshake.
    cyc(4'b0001, 0, 0, 0, 4'h0, 32'd0);
    idle(1);
    cyc('0, 0, 0, 1, 4'h0, 32'h1F);
    check_eq("s5_hold", 32'(eip), 32'd1);
    idle(1);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);
    idle(5);
    check_eq("s5_quiet", 32'(eip), 32'd0);
    peek(4'h0, 32'd0, "s5_pend");

    // Reset in the middle of ASSERT.
    cyc(4'b0100, 0, 0, 0, 4'h0, 32'd0);
    idle(1);
    check_eq("s6_pre", 32'(eip), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("s6_async_eip", 32'(eip), 32'd0);
    peek(4'h0, 32'd0, "s6_async_pend");
    irq = '1; timer_irq = 1'b1; eip_reply = 1'b1;
    @(posedge clk);
    @(negedge clk);
    irq = '0; timer_irq = 1'b0; eip_reply = 1'b0;
    model_reset();
    peek(4'h0, 32'd0, "s6_nosample");
    peek(4'h8, 32'd0, "s6_claim");
    rst = 1'b1;
    cyc('0, 0, 0, 1, 4'h4, 32'h1F);
    cyc(4'b0001, 0, 0, 0, 4'h0, 32'd0);
    idle(1);
    check_eq("s6_idle_ok", 32'(eip), 32'd1);
    cyc('0, 0, 1, 0, 4'h0, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] iv;
      for (int j = 0; j < N; j++) iv[j] = ($urandom_range(7) == 0);
      cyc(iv, $urandom_range(9) == 0, $urandom_range(2) == 0,
          $urandom_range(7) == 0, 4'($urandom_range(15)), $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4: number of external interrupt sources, 1..8.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous and active-low.
REQ-004 SHALL have port irq, input, NSRC: external source requests; each is a one-cycle pulse per event.
REQ-005 SHALL have port timer_irq, input, 1: timer request; one-cycle pulse per event.
REQ-006 SHALL have port a, input, 4: register byte address; bits [3:2] select the word.
REQ-007 SHALL have port d, input, 32: write data.
REQ-008 SHALL have port we, input, 1: write strobe; one write per cycle with we=1.
REQ-009 SHALL have port spo, output, 32: combinational read data for the current a.
REQ-010 SHALL have port eip, output, 1: interrupt pending to the privilege unit; level, held until replied.
REQ-011 SHALL have port eip_istimer, output, 1: qualifies eip; 1 = timer, 0 = external.
REQ-012 SHALL have port eip_reply, input, 1: acknowledge from the privilege unit; may be a one-cycle pulse.

Function
REQ-013 SHALL keep pend[NSRC:0]: bits [NSRC-1:0] are external sources, bit NSRC is the timer.
REQ-014 SHALL set pend[i] on the cycle after a pulse on source i arrives; a pulse while the bit is already set merges into it and is not counted.
REQ-015 SHALL keep mask[NSRC:0], which is read/write; eligible = pend & mask.
REQ-016 SHALL implement the register map, with unmapped bits reading 0:
 - 0x0 PENDING: read returns pend; write clears every bit where d=1 (W1C).
 - 0x4 MASK: read/write.
 - 0x8 CLAIM: read-only; {valid[31], istimer[8], id[2:0]} of the last granted request.
 - 0xC: reads 0; writes ignored.
REQ-017 SHALL give a set event priority over a W1C clear or a grant clear of the same bit in the same cycle (bit ends set).
REQ-018 SHALL use a state machine with states IDLE, ASSERT and GAP.
REQ-019 In IDLE, when eligible is nonzero, SHALL on the next edge:
 - latch the grant as the lowest-index eligible external source; the timer is granted only if no external source is eligible;
 - set eip=1, set eip_istimer accordingly, and go to ASSERT.
REQ-020 In ASSERT, SHALL hold eip, eip_istimer and the grant stable regardless of pend/mask changes.
REQ-021 In ASSERT, on eip_reply=1, SHALL on the next edge:
 - drive eip=0 and eip_istimer=0;
 - clear pend[grant], unless REQ-017 applies;
 - update CLAIM with valid=1 and the grant;
 - load gap counter to 2 and go to GAP.
REQ-022 In GAP, SHALL decrement the counter each cycle and return to IDLE when it reaches 0; eip is therefore low for at least 3 cycles between requests.
REQ-023 SHALL ignore eip_reply in IDLE and GAP.
REQ-024 If the granted bit is cleared by W1C during ASSERT, SHALL still complete the handshake normally.
REQ-025 SHALL allow mask writes at any time; they affect only the next IDLE arbitration.

Reset
REQ-026 While rst=0, SHALL asynchronously force:
 - pend=0, mask=0, CLAIM=0;
 - eip=0, eip_istimer=0;
 - state=IDLE, gap counter=0.
REQ-027 SHALL abandon an in-flight ASSERT on reset: no CLAIM update, and eip drops immediately.
REQ-028 SHALL sample no pulses while rst=0.

Verification
REQ-029 SHALL pass, in each directed scenario below, with the stated stimulus and required response:
 - mask=0x1F, irq[2] pulse: eip=1 and eip_istimer=0 two cycles later; eip_reply pulse gives eip=0 next cycle, CLAIM=0x80000002 and PENDING=0.
 - mask=0x1F, timer_irq and irq[3] pulse together: external is granted first (CLAIM id=3); after GAP, timer is granted with eip_istimer=1 and CLAIM=0x80000100.
 - mask=0x00, irq[0] pulse: PENDING=0x01 and eip stays 0; writing mask=0x01 gives eip=1 within 2 cycles.
 - In ASSERT, irq[1] pulses again in the same cycle eip_reply is sampled: PENDING bit 1 remains set and a second request follows after GAP.
 - Write PENDING=0x1F during ASSERT: eip stays 1 until eip_reply; afterwards PENDING=0 and no new request.
 - Assert rst low mid-ASSERT: eip=0 and PENDING=0 asynchronously; after release, CLAIM=0 and state is IDLE.
